// File: rtl/mip_s2mm_writer_if.sv
// rtl/mip_s2mm_writer_if.sv - job, result-stream, S2MM command/data/status signals of mip_s2mm_writer
interface mip_s2mm_writer_if;
  logic         job_valid;
  logic         job_ready;
  logic [63:0]  job_addr;
  logic [22:0]  job_bytes;

  logic [127:0] s_data_tdata;
  logic         s_data_tvalid;
  logic         s_data_tready;

  logic [95:0]  m_axis_s2mm_cmd_tdata;
  logic         m_axis_s2mm_cmd_tvalid;
  logic         m_axis_s2mm_cmd_tready;

  logic [127:0] m_axis_s2mm_tdata;
  logic [15:0]  m_axis_s2mm_tkeep;
  logic         m_axis_s2mm_tlast;
  logic         m_axis_s2mm_tvalid;
  logic         m_axis_s2mm_tready;

  logic [7:0]   s_axis_s2mm_sts_tdata;
  logic         s_axis_s2mm_sts_tvalid;
  logic         s_axis_s2mm_sts_tready;
  logic         s_axis_s2mm_sts_tkeep;
  logic         s_axis_s2mm_sts_tlast;

  // master: the writer itself; slave: the job source, pipeline and DataMover around it
  modport master (
    input  job_valid, job_addr, job_bytes,
    output job_ready,
    input  s_data_tdata, s_data_tvalid,
    output s_data_tready,
    output m_axis_s2mm_cmd_tdata, m_axis_s2mm_cmd_tvalid,
    input  m_axis_s2mm_cmd_tready,
    output m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid,
    input  m_axis_s2mm_tready,
    input  s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tlast,
    output s_axis_s2mm_sts_tready
  );

  modport slave (
    output job_valid, job_addr, job_bytes,
    input  job_ready,
    output s_data_tdata, s_data_tvalid,
    input  s_data_tready,
    input  m_axis_s2mm_cmd_tdata, m_axis_s2mm_cmd_tvalid,
    output m_axis_s2mm_cmd_tready,
    input  m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast, m_axis_s2mm_tvalid,
    output m_axis_s2mm_tready,
    output s_axis_s2mm_sts_tdata, s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tlast,
    input  s_axis_s2mm_sts_tready
  );
endinterface

// File: rtl/mip_s2mm_writer.sv
// rtl/mip_s2mm_writer.sv - DataMover S2MM write-back initiator: one job -> one command, data, status
// Optional S2MM_PERF_CNT_EN adds perf_jobs_o/perf_beats_o counters.
module mip_s2mm_writer #(
  parameter logic [22:0] MAX_BTT = 23'h7FFFF0,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  mip_s2mm_writer_if.master bus,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic [7:0]  last_sts_o
`ifdef S2MM_PERF_CNT_EN
  ,
  output logic [31:0] perf_jobs_o,
  output logic [31:0] perf_beats_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    DATA     = 2'd2,
    WAIT_STS = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [63:0]  addr_q, addr_d;
  logic [22:0]  bytes_q, bytes_d;
  logic [19:0]  beats_q, beats_d;
  logic [19:0]  in_left_q, in_left_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [2:0]   err_code_q, err_code_d;
  logic [7:0]   last_sts_q, last_sts_d;

  logic         job_ready;
  logic         cmd_tvalid;
  logic         sts_tready;
  logic         in_fire;
  logic         out_fire;
  logic         in_last;
  logic [15:0]  last_keep;
  logic [15:0]  in_keep;
  logic [19:0]  job_beats;
  logic         sts_ok;
  logic         sts_unused;

  assign sts_unused = ^{bus.s_axis_s2mm_sts_tkeep, bus.s_axis_s2mm_sts_tlast};

  assign job_beats = {1'b0, bus.job_bytes[22:4]} + {19'd0, |bus.job_bytes[3:0]};
  assign last_keep = (bytes_q[3:0] == 4'd0) ? 16'hFFFF : ((16'd1 << bytes_q[3:0]) - 16'd1);
  assign in_last   = (in_left_q == 20'd1);
  assign in_keep   = in_last ? last_keep : 16'hFFFF;
  assign sts_ok    = bus.s_axis_s2mm_sts_tdata[7] && (bus.s_axis_s2mm_sts_tdata[6:4] == 3'b000);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    beats_d    = beats_q;
    in_left_d  = in_left_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    last_sts_d = last_sts_q;
    job_ready  = 1'b0;
    cmd_tvalid = 1'b0;
    sts_tready = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) begin
          addr_d     = bus.job_addr;
          bytes_d    = bus.job_bytes;
          err_code_d = 3'b000;
          if ((bus.job_bytes == 23'd0) || (bus.job_bytes > MAX_BTT)) begin
            err_d      = 1'b1;
            err_code_d = 3'b001;
          end else if (bus.job_addr[3:0] != 4'd0) begin
            err_d      = 1'b1;
            err_code_d = 3'b010;
          end else begin
            busy_d    = 1'b1;
            beats_d   = job_beats;
            in_left_d = job_beats;
            state_d   = CMD;
          end
        end
      end
      CMD: begin
        cmd_tvalid = 1'b1;
        if (bus.m_axis_s2mm_cmd_tready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (in_fire) begin
          in_left_d = in_left_q - 20'd1;
        end
        if (out_fire) begin
          beats_d = beats_q - 20'd1;
          if (beats_q == 20'd1) begin
            state_d = WAIT_STS;
          end
        end
      end
      WAIT_STS: begin
        sts_tready = 1'b1;
        if (bus.s_axis_s2mm_sts_tvalid) begin
          last_sts_d = bus.s_axis_s2mm_sts_tdata;
          busy_d     = 1'b0;
          state_d    = IDLE;
          if (sts_ok) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 3'b100;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      bytes_q    <= 23'd0;
      beats_q    <= 20'd0;
      in_left_q  <= 20'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'b000;
      last_sts_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      beats_q    <= beats_d;
      in_left_q  <= in_left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      last_sts_q <= last_sts_d;
    end
  end

  // tkeep/tlast are attached to each word as it enters, so the buffer carries them along
  if (SKID_EN) begin : g_skid
    logic [144:0] out_q, out_d, skid_q, skid_d;
    logic         out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [144:0] in_payload;
    logic         s_tready;

    assign in_payload = {in_last, in_keep, bus.s_data_tdata};
    assign s_tready   = (state_q == DATA) && (in_left_q != 20'd0) && !skid_vld_q;
    assign in_fire    = s_tready && bus.s_data_tvalid;
    assign out_fire   = out_vld_q && bus.m_axis_s2mm_tready;

    always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!out_vld_q || out_fire) begin
        if (skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          out_d     = in_payload;
          out_vld_d = in_fire;
        end
      end else if (in_fire) begin
        skid_d     = in_payload;
        skid_vld_d = 1'b1;
      end
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        out_q      <= '0;
        out_vld_q  <= 1'b0;
        skid_q     <= '0;
        skid_vld_q <= 1'b0;
      end else begin
        out_q      <= out_d;
        out_vld_q  <= out_vld_d;
        skid_q     <= skid_d;
        skid_vld_q <= skid_vld_d;
      end
    end

    assign bus.s_data_tready      = s_tready;
    assign bus.m_axis_s2mm_tvalid = out_vld_q;
    assign bus.m_axis_s2mm_tlast  = out_q[144];
    assign bus.m_axis_s2mm_tkeep  = out_q[143:128];
    assign bus.m_axis_s2mm_tdata  = out_q[127:0];
  end else begin : g_pass
    logic active;

    assign active                 = (state_q == DATA) && (in_left_q != 20'd0);
    assign bus.s_data_tready      = active && bus.m_axis_s2mm_tready;
    assign bus.m_axis_s2mm_tvalid = active && bus.s_data_tvalid;
    assign bus.m_axis_s2mm_tlast  = in_last;
    assign bus.m_axis_s2mm_tkeep  = in_keep;
    assign bus.m_axis_s2mm_tdata  = bus.s_data_tdata;
    assign in_fire                = active && bus.s_data_tvalid && bus.m_axis_s2mm_tready;
    assign out_fire               = in_fire;
  end

`ifdef S2MM_PERF_CNT_EN
  logic [31:0] perf_jobs_q, perf_beats_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_jobs_q  <= 32'd0;
      perf_beats_q <= 32'd0;
    end else begin
      if (done_d) begin
        perf_jobs_q <= perf_jobs_q + 32'd1;
      end
      if (out_fire) begin
        perf_beats_q <= perf_beats_q + 32'd1;
      end
    end
  end

  assign perf_jobs_o  = perf_jobs_q;
  assign perf_beats_o = perf_beats_q;
`endif

  // command word: {SADDR, DRR=0, EOF=1, DSA=0, TYPE=1 (INCR), BTT}
  assign bus.m_axis_s2mm_cmd_tdata  = {addr_q, 1'b0, 1'b1, 6'd0, 1'b1, bytes_q};
  assign bus.m_axis_s2mm_cmd_tvalid = cmd_tvalid;
  assign bus.job_ready              = job_ready;
  assign bus.s_axis_s2mm_sts_tready = sts_tready;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign last_sts_o = last_sts_q;

endmodule

// File: tb/tb_mip_s2mm_writer.sv
// tb/tb_mip_s2mm_writer.sv - directed and randomized jobs against a queue-based reference model
module tb_mip_s2mm_writer;
  localparam logic [22:0] MAX_BTT = 23'h7FFFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [7:0]  last_sts;
  int          vectors = 0;
  int          miscompares = 0;
  int          jobs_ok_model = 0;
  int          beats_model = 0;
`ifdef S2MM_PERF_CNT_EN
  logic [31:0] perf_jobs, perf_beats;
`endif

  mip_s2mm_writer_if bus_if ();

  mip_s2mm_writer #(.MAX_BTT(MAX_BTT), .SKID_EN(1'b1)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .bus        (bus_if),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code),
    .last_sts_o (last_sts)
`ifdef S2MM_PERF_CNT_EN
    ,
    .perf_jobs_o  (perf_jobs),
    .perf_beats_o (perf_beats)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_keep(input int k, input int beats, input int nbytes);
    int r;
    logic [15:0] kp;
    if (k < beats - 1) return 16'hFFFF;
    r = nbytes % 16;
    if (r == 0) return 16'hFFFF;
    kp = 16'h0000;
    for (int i = 0; i < r; i++) kp[i] = 1'b1;
    return kp;
  endfunction

  task automatic drive_idle();
    bus_if.job_valid              = 1'b0;
    bus_if.s_data_tvalid          = 1'b0;
    bus_if.m_axis_s2mm_cmd_tready = 1'b0;
    bus_if.m_axis_s2mm_tready     = 1'b0;
    bus_if.s_axis_s2mm_sts_tvalid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_job_ready"}, 128'(bus_if.job_ready), 128'(1));
    chk({tag, "_cmd_tvalid"}, 128'(bus_if.m_axis_s2mm_cmd_tvalid), 128'(0));
    chk({tag, "_tvalid"}, 128'(bus_if.m_axis_s2mm_tvalid), 128'(0));
    chk({tag, "_s_tready"}, 128'(bus_if.s_data_tready), 128'(0));
    chk({tag, "_sts_tready"}, 128'(bus_if.s_axis_s2mm_sts_tready), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_err_code"}, 128'(err_code), 128'(0));
    chk({tag, "_last_sts"}, 128'(last_sts), 128'(0));
  endtask

  // abort_at >= 0: assert reset once that many beats have left the DUT
  task automatic run_job(input logic [63:0] addr, input logic [22:0] nbytes, input logic [7:0] sts,
                         input bit bp, input int abort_at);
    int           beats, in_idx, out_idx, cyc;
    logic [127:0] words[$];
    logic [95:0]  exp_cmd;
    logic [2:0]   exp_code;
    bit           cmd_acc, sts_acc, sts_phase, aborted, ok;
    in_idx = 0; out_idx = 0; cyc = 0;
    cmd_acc = 0; sts_acc = 0; aborted = 0;
    exp_code = 3'b000;
    if (nbytes == 23'd0 || nbytes > MAX_BTT) exp_code = 3'b001;
    else if (addr % 16 != 0) exp_code = 3'b010;

    @(negedge clock);
    bus_if.job_valid = 1'b1;
    bus_if.job_addr  = addr;
    bus_if.job_bytes = nbytes;
    #1 chk("job_ready_idle", 128'(bus_if.job_ready), 128'(1));
    @(negedge clock);
    bus_if.job_valid = 1'b0;
    if (exp_code != 3'b000) begin
      #1;
      chk("err_pulse", 128'(err), 128'(1));
      chk("err_code", 128'(err_code), 128'(exp_code));
      chk("err_busy", 128'(busy), 128'(0));
      chk("err_done", 128'(done), 128'(0));
      chk("err_cmd_tvalid", 128'(bus_if.m_axis_s2mm_cmd_tvalid), 128'(0));
      @(negedge clock); #1;
      chk("err_pulse_end", 128'(err), 128'(0));
      chk("err_code_hold", 128'(err_code), 128'(exp_code));
      chk("err_cmd_tvalid2", 128'(bus_if.m_axis_s2mm_cmd_tvalid), 128'(0));
      return;
    end

    beats = (int'(nbytes) + 15) / 16;
    for (int i = 0; i < beats + 3; i++) words.push_back({$urandom, $urandom, $urandom, $urandom});
    exp_cmd = (96'(addr) << 32) + (96'(1) << 30) + (96'(1) << 23) + 96'(nbytes);

    while (!sts_acc && cyc < 6000) begin
      bus_if.m_axis_s2mm_cmd_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.m_axis_s2mm_tready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.s_data_tvalid          = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.s_data_tdata           = words[in_idx];
      sts_phase = (out_idx == beats);
      if (sts_phase) begin
        bus_if.s_axis_s2mm_sts_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_if.s_axis_s2mm_sts_tdata  = sts;
      end else begin
        bus_if.s_axis_s2mm_sts_tvalid = bp;
        bus_if.s_axis_s2mm_sts_tdata  = 8'h40;
      end
      if (abort_at >= 0 && out_idx == abort_at) begin
        drive_idle();
        reset   = 1'b1;
        aborted = 1;
        break;
      end
      #1;
      chk("busy", 128'(busy), 128'(1));
      chk("done_early", 128'(done), 128'(0));
      chk("err_early", 128'(err), 128'(0));
      chk("err_code_clear", 128'(err_code), 128'(0));
      chk("job_ready_busy", 128'(bus_if.job_ready), 128'(0));
      chk("cmd_tvalid", 128'(bus_if.m_axis_s2mm_cmd_tvalid), 128'(!cmd_acc));
      if (!cmd_acc) begin
        chk("data_before_cmd", 128'(bus_if.m_axis_s2mm_tvalid), 128'(0));
        chk("in_before_cmd", 128'(bus_if.s_data_tready), 128'(0));
      end
      if (bus_if.m_axis_s2mm_cmd_tvalid) begin
        chk("cmd_tdata", 128'(bus_if.m_axis_s2mm_cmd_tdata), 128'(exp_cmd));
        if (bus_if.m_axis_s2mm_cmd_tready) cmd_acc = 1;
      end
      if (in_idx >= beats) chk("in_stall", 128'(bus_if.s_data_tready), 128'(0));
      if (bus_if.s_data_tvalid && bus_if.s_data_tready) in_idx++;
      if (bus_if.m_axis_s2mm_tvalid && bus_if.m_axis_s2mm_tready) begin
        if (out_idx < beats) begin
          chk("tdata", bus_if.m_axis_s2mm_tdata, words[out_idx]);
          chk("tkeep", 128'(bus_if.m_axis_s2mm_tkeep), 128'(exp_keep(out_idx, beats, int'(nbytes))));
          chk("tlast", 128'(bus_if.m_axis_s2mm_tlast), 128'(out_idx == beats - 1));
        end else begin
          chk("extra_beat", 128'(out_idx), 128'(beats - 1));
        end
        out_idx++;
        beats_model++;
      end
      if (bus_if.s_axis_s2mm_sts_tvalid) begin
        chk("sts_tready", 128'(bus_if.s_axis_s2mm_sts_tready), 128'(sts_phase));
        if (bus_if.s_axis_s2mm_sts_tready && sts_phase) sts_acc = 1;
      end
      @(negedge clock);
      cyc++;
    end

    if (aborted) begin
      @(negedge clock); #1;
      chk_reset_state("mid_reset");
      beats_model   = 0;
      jobs_ok_model = 0;
      reset = 1'b0;
      return;
    end

    drive_idle();
    chk("job_completed_in_time", 128'(sts_acc), 128'(1));
    chk("beat_count", 128'(out_idx), 128'(beats));
    #1;
    ok = sts[7] && (sts[6:4] == 3'b000);
    if (ok) jobs_ok_model++;
    chk("done_pulse", 128'(done), 128'(ok));
    chk("err_pulse_sts", 128'(err), 128'(!ok));
    chk("err_code_sts", 128'(err_code), 128'(ok ? 3'b000 : 3'b100));
    chk("busy_drop", 128'(busy), 128'(0));
    chk("last_sts", 128'(last_sts), 128'(sts));
    chk("job_ready_after", 128'(bus_if.job_ready), 128'(1));
    @(negedge clock); #1;
    chk("done_end", 128'(done), 128'(0));
    chk("err_end", 128'(err), 128'(0));
  endtask

  initial begin
    logic [7:0]  rs;
    logic [22:0] rb;
    bus_if.job_addr               = 64'd0;
    bus_if.job_bytes              = 23'd0;
    bus_if.s_data_tdata           = 128'd0;
    bus_if.s_axis_s2mm_sts_tdata  = 8'd0;
    bus_if.s_axis_s2mm_sts_tkeep  = 1'b1;
    bus_if.s_axis_s2mm_sts_tlast  = 1'b1;
    drive_idle();

    repeat (3) @(negedge clock);
    #1 chk_reset_state("reset");
    reset = 1'b0;

    run_job(64'h1000, 23'd64, 8'h80, 1'b0, -1);
    run_job(64'h2000, 23'd37, 8'h8A, 1'b0, -1);
    run_job(64'h3000, 23'd0, 8'h80, 1'b0, -1);
    run_job(64'h1008, 23'd16, 8'h80, 1'b0, -1);
    run_job(64'h4000, MAX_BTT + 23'd1, 8'h80, 1'b0, -1);
    run_job(64'h5000, 23'd1, 8'h83, 1'b0, -1);
    run_job(64'h6000, 23'd16, 8'h80, 1'b1, -1);
    run_job(64'h7000, 23'd50, 8'hC0, 1'b0, -1);
    run_job(64'h8000, 23'd33, 8'h00, 1'b1, -1);
    run_job({$urandom, $urandom} & ~64'hF, 23'd4096, 8'h85, 1'b1, -1);
    run_job(64'h9000, 23'd4096, 8'h80, 1'b1, 10);
    run_job(64'hA000, 23'd100, 8'h80, 1'b1, -1);

    for (int j = 0; j < 4; j++) begin
      rb = 23'($urandom_range(1, 700));
      rs = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rs[7]   = 1'b1;
        rs[6:4] = 3'b000;
      end
      run_job({$urandom, $urandom} & ~64'hF, rb, rs, 1'($urandom_range(0, 1)), -1);
    end

`ifdef S2MM_PERF_CNT_EN
    chk("perf_jobs", 128'(perf_jobs), 128'(jobs_ok_model));
    chk("perf_beats", 128'(perf_beats), 128'(beats_model));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
